// File: rtl/intdiv_pkg.sv
// Shared types and sizing helpers for the integer divider pre-normalization path.
package intdiv_pkg;

  typedef enum logic [2:0] {IDLE, LZX, LZD, SHIFT, DONE} prenorm_state_t;

  // Iteration count needs one extra bit so that a full WIDTH-bit quotient is representable.
  function automatic int unsigned iter_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/intdiv_prenorm_if.sv
// Operand/result handshake bundle between the divider front end and pre-normalization.
interface intdiv_prenorm_if #(parameter int unsigned WIDTH = 64);
  import intdiv_pkg::*;

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned IW = iter_width(WIDTH);

  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] D;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] XNorm;
  logic [WIDTH-1:0] DNorm;
  logic [SW-1:0]    XShift;
  logic [SW-1:0]    DShift;
  logic             XZero;
  logic             DivZero;
  logic [IW-1:0]    Iter;

  modport master (
    output InValid, X, D, OutReady,
    input  InReady, OutValid, XNorm, DNorm, XShift, DShift, XZero, DivZero, Iter
  );

  modport slave (
    input  InValid, X, D, OutReady,
    output InReady, OutValid, XNorm, DNorm, XShift, DShift, XZero, DivZero, Iter
  );

endinterface

// File: rtl/lzd_hier.sv
// Hierarchical leading-zero detector; a zero input reports ZP all ones with ZV low.
module lzd_hier #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0]         a,
  output logic [$clog2(WIDTH)-1:0] zp,
  output logic                     zv
);

  generate
    if (WIDTH == 2) begin : g_leaf
      assign zv = |a;
      assign zp = ~a[1];
    end else begin : g_node
      localparam int unsigned H = WIDTH / 2;
      logic [$clog2(H)-1:0] zph;
      logic [$clog2(H)-1:0] zpl;
      logic                 zvh;
      logic                 zvl;

      lzd_hier #(.WIDTH(H)) u_hi (.a(a[WIDTH-1:H]), .zp(zph), .zv(zvh));
      lzd_hier #(.WIDTH(H)) u_lo (.a(a[H-1:0]),     .zp(zpl), .zv(zvl));

      // An all-zero upper half with an all-zero lower half naturally yields all ones.
      assign zv = zvh | zvl;
      assign zp = zvh ? {1'b0, zph} : {1'b1, zpl};
    end
  endgenerate

endmodule

// File: rtl/intdiv_prenorm.sv
// Pre-normalization sequencer: one shared LZD counts X then D, then both are left-justified.
module intdiv_prenorm
  import intdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input logic             clk,
  input logic             resetn,
  intdiv_prenorm_if.slave bus
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned IW = iter_width(WIDTH);

  prenorm_state_t   state;
  prenorm_state_t   state_nx;
  logic [WIDTH-1:0] xreg;
  logic [WIDTH-1:0] dreg;
  logic [WIDTH-1:0] lzd_in;
  logic [SW-1:0]    zp;
  logic             zv;
  logic             in_ready;
  logic             accept;
  logic [IW-1:0]    iter_nx;

  assign lzd_in = (state == LZD) ? dreg : xreg;

  lzd_hier #(.WIDTH(WIDTH)) u_lzd (.a(lzd_in), .zp(zp), .zv(zv));

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.InValid) state_nx = LZX;
      end
      LZX:   state_nx = LZD;
      LZD:   state_nx = SHIFT;
      SHIFT: state_nx = DONE;
      DONE: begin
        in_ready = bus.OutReady;
        if (bus.OutReady) state_nx = bus.InValid ? LZX : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept      = bus.InValid & in_ready;
  assign bus.InReady = in_ready;

  always_comb begin
    iter_nx = '0;
    if (!(bus.XZero | bus.DivZero) && !(bus.XShift > bus.DShift))
      iter_nx = {1'b0, bus.DShift} - {1'b0, bus.XShift} + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      xreg         <= '0;
      dreg         <= '0;
      bus.OutValid <= 1'b0;
      bus.XNorm    <= '0;
      bus.DNorm    <= '0;
      bus.XShift   <= '0;
      bus.DShift   <= '0;
      bus.XZero    <= 1'b0;
      bus.DivZero  <= 1'b0;
      bus.Iter     <= '0;
    end else begin
      state        <= state_nx;
      // OutValid tracks the DONE state but is registered so reset clears it with the rest.
      bus.OutValid <= (state_nx == DONE);
      if (accept) begin
        xreg <= bus.X;
        dreg <= bus.D;
      end
      case (state)
        LZX: begin
          bus.XShift <= zp;
          bus.XZero  <= ~zv;
        end
        LZD: begin
          bus.DShift  <= zp;
          bus.DivZero <= ~zv;
        end
        SHIFT: begin
          bus.XNorm <= xreg << bus.XShift;
          bus.DNorm <= dreg << bus.DShift;
          bus.Iter  <= iter_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intdiv_prenorm.sv
// Directed bench for intdiv_prenorm at WIDTH=8 and WIDTH=64.
module tb_intdiv_prenorm;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  intdiv_prenorm_if #(.WIDTH(8))  b8();
  intdiv_prenorm_if #(.WIDTH(64)) b64();

  intdiv_prenorm #(.WIDTH(8))  dut8  (.clk(clk), .resetn(resetn), .bus(b8.slave));
  intdiv_prenorm #(.WIDTH(64)) dut64 (.clk(clk), .resetn(resetn), .bus(b64.slave));

  always #5 clk = ~clk;

  // {XNorm, DNorm, XShift, DShift, XZero, DivZero, Iter}
  function automatic logic [27:0] res8();
    return {b8.XNorm, b8.DNorm, b8.XShift, b8.DShift, b8.XZero, b8.DivZero, b8.Iter};
  endfunction

  function automatic logic [149:0] res64();
    return {b64.XNorm, b64.DNorm, b64.XShift, b64.DShift, b64.XZero, b64.DivZero, b64.Iter};
  endfunction

  task automatic op8(input logic [7:0] x, input logic [7:0] d, output int lat);
    @(negedge clk);
    b8.X = x;
    b8.D = d;
    b8.InValid = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) b8.InValid = 1'b0;
    end while (!b8.OutValid && lat < 20);
  endtask

  task automatic op64(input logic [63:0] x, input logic [63:0] d, output int lat);
    @(negedge clk);
    b64.X = x;
    b64.D = d;
    b64.InValid = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) b64.InValid = 1'b0;
    end while (!b64.OutValid && lat < 20);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (res8() !== 28'h0) begin
      errors++; $display("FAIL reset_res8: got %h want 0", res8());
    end
    checks++;
    if (b8.OutValid !== 1'b0 || b8.InReady !== 1'b1) begin
      errors++; $display("FAIL reset_hs8: got valid=%b ready=%b want valid=0 ready=1", b8.OutValid, b8.InReady);
    end
    checks++;
    if (res64() !== 150'h0) begin
      errors++; $display("FAIL reset_res64: got %h want 0", res64());
    end
    checks++;
    if (b64.OutValid !== 1'b0 || b64.InReady !== 1'b1) begin
      errors++; $display("FAIL reset_hs64: got valid=%b ready=%b want valid=0 ready=1", b64.OutValid, b64.InReady);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    op8(8'h30, 8'h05, lat);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL basic_latency: got %0d want 4", lat);
    end
    checks++;
    if (b8.XShift !== 3'd2 || b8.DShift !== 3'd5) begin
      errors++; $display("FAIL basic_shift: got x=%0d d=%0d want x=2 d=5", b8.XShift, b8.DShift);
    end
    checks++;
    if (b8.XNorm !== 8'hC0 || b8.DNorm !== 8'hA0) begin
      errors++; $display("FAIL basic_norm: got x=%h d=%h want x=c0 d=a0", b8.XNorm, b8.DNorm);
    end
    checks++;
    if (b8.Iter !== 4'd4 || b8.XZero !== 1'b0 || b8.DivZero !== 1'b0) begin
      errors++; $display("FAIL basic_iter: got iter=%0d xz=%b dz=%b want 4 0 0", b8.Iter, b8.XZero, b8.DivZero);
    end
  endtask

  task automatic test_iter_rules();
    int lat;
    op8(8'h03, 8'h40, lat);
    checks++;
    if (lat !== 4 || res8() !== {8'hC0, 8'h80, 3'd6, 3'd1, 1'b0, 1'b0, 4'd0}) begin
      errors++; $display("FAIL iter_xgt: got lat=%0d res=%h want lat=4 res=%h", lat, res8(), {8'hC0, 8'h80, 3'd6, 3'd1, 1'b0, 1'b0, 4'd0});
    end
    op8(8'hFF, 8'h01, lat);
    checks++;
    if (lat !== 4 || res8() !== {8'hFF, 8'h80, 3'd0, 3'd7, 1'b0, 1'b0, 4'd8}) begin
      errors++; $display("FAIL iter_max8: got lat=%0d res=%h want lat=4 res=%h", lat, res8(), {8'hFF, 8'h80, 3'd0, 3'd7, 1'b0, 1'b0, 4'd8});
    end
    op8(8'h80, 8'h80, lat);
    checks++;
    if (lat !== 4 || res8() !== {8'h80, 8'h80, 3'd0, 3'd0, 1'b0, 1'b0, 4'd1}) begin
      errors++; $display("FAIL iter_equal: got lat=%0d res=%h want lat=4 res=%h", lat, res8(), {8'h80, 8'h80, 3'd0, 3'd0, 1'b0, 1'b0, 4'd1});
    end
  endtask

  task automatic test_zero_operands();
    int lat;
    op8(8'h11, 8'h00, lat);
    checks++;
    if (lat !== 4 || res8() !== {8'h88, 8'h00, 3'd3, 3'd7, 1'b0, 1'b1, 4'd0}) begin
      errors++; $display("FAIL divzero: got lat=%0d res=%h want lat=4 res=%h", lat, res8(), {8'h88, 8'h00, 3'd3, 3'd7, 1'b0, 1'b1, 4'd0});
    end
    op8(8'h00, 8'h01, lat);
    checks++;
    if (lat !== 4 || res8() !== {8'h00, 8'h80, 3'd7, 3'd7, 1'b1, 1'b0, 4'd0}) begin
      errors++; $display("FAIL xzero: got lat=%0d res=%h want lat=4 res=%h", lat, res8(), {8'h00, 8'h80, 3'd7, 3'd7, 1'b1, 1'b0, 4'd0});
    end
  endtask

  task automatic test_wide();
    int lat;
    op64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat);
    checks++;
    if (lat !== 4 || b64.XShift !== 6'd0 || b64.DShift !== 6'd63) begin
      errors++; $display("FAIL wide_shift: got lat=%0d x=%0d d=%0d want 4 0 63", lat, b64.XShift, b64.DShift);
    end
    checks++;
    if (b64.Iter !== 7'd64 || b64.XNorm !== 64'hFFFF_FFFF_FFFF_FFFF || b64.DNorm !== 64'h8000_0000_0000_0000) begin
      errors++; $display("FAIL wide_iter: got iter=%0d xn=%h dn=%h want 64 ffffffffffffffff 8000000000000000", b64.Iter, b64.XNorm, b64.DNorm);
    end
    op64(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    checks++;
    if (lat !== 4 || res64() !== {64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 6'd0, 1'b0, 1'b0, 7'd0}) begin
      errors++; $display("FAIL wide_xgt: got lat=%0d res=%h", lat, res64());
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    int bad;
    b8.OutReady = 1'b0;
    op8(8'h30, 8'h05, lat);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL bp_latency: got %0d want 4", lat);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b8.OutValid !== 1'b1 || b8.InReady !== 1'b0 || res8() !== {8'hC0, 8'hA0, 3'd2, 3'd5, 1'b0, 1'b0, 4'd4})
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
    end
    b8.OutReady = 1'b1;
    b8.X = 8'h03;
    b8.D = 8'h40;
    b8.InValid = 1'b1;
    #1;
    checks++;
    if (b8.InReady !== 1'b1) begin
      errors++; $display("FAIL bp_inready: got %b want 1", b8.InReady);
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) b8.InValid = 1'b0;
    end while (!b8.OutValid && lat < 20);
    checks++;
    if (lat !== 4 || res8() !== {8'hC0, 8'h80, 3'd6, 3'd1, 1'b0, 1'b0, 4'd0}) begin
      errors++; $display("FAIL bp_next: got lat=%0d res=%h want lat=4 res=%h", lat, res8(), {8'hC0, 8'h80, 3'd6, 3'd1, 1'b0, 1'b0, 4'd0});
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int bad;
    @(negedge clk);
    b8.OutReady = 1'b1;
    b8.X = 8'h30;
    b8.D = 8'h05;
    b8.InValid = 1'b1;
    @(posedge clk);
    pulses = 0;
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (b8.OutValid) pulses++;
      if (b8.OutValid !== (k % 4 == 0)) bad++;
      if (k == 16) b8.InValid = 1'b0;
    end
    checks++;
    if (pulses !== 4 || bad !== 0) begin
      errors++; $display("FAIL b2b_rate: got pulses=%0d misplaced=%0d want pulses=4 misplaced=0", pulses, bad);
    end
    checks++;
    if (res8() !== {8'hC0, 8'hA0, 3'd2, 3'd5, 1'b0, 1'b0, 4'd4}) begin
      errors++; $display("FAIL b2b_res: got %h want %h", res8(), {8'hC0, 8'hA0, 3'd2, 3'd5, 1'b0, 1'b0, 4'd4});
    end
  endtask

  task automatic test_reset_mid();
    int spurious;
    @(negedge clk);
    b8.X = 8'h30;
    b8.D = 8'h05;
    b8.InValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b8.InValid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (res8() !== 28'h0 || b8.OutValid !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear: got res=%h valid=%b want 0 0", res8(), b8.OutValid);
    end
    checks++;
    if (b8.InReady !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready: got %b want 1", b8.InReady);
    end
    resetn = 1'b1;
    spurious = 0;
    repeat (8) begin
      @(negedge clk);
      if (b8.OutValid !== 1'b0) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      errors++; $display("FAIL rstmid_spurious: got %0d valid cycles want 0", spurious);
    end
  endtask

  initial begin
    b8.InValid  = 1'b0;
    b8.OutReady = 1'b1;
    b8.X        = '0;
    b8.D        = '0;
    b64.InValid  = 1'b0;
    b64.OutReady = 1'b1;
    b64.X        = '0;
    b64.D        = '0;

    test_reset();
    test_basic();
    test_iter_rules();
    test_zero_operands();
    test_wide();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intdiv_prenorm.md
# intdiv_prenorm

Pre-normalization sequencer for the integer divider. Accepts an unsigned dividend/divisor pair over a valid/ready handshake and time-multiplexes a single `lzd_hier` leading-zero detector across both operands. Produces left-justified operands, their shift amounts, divide-by-zero and zero-dividend flags, and the quotient-bit iteration count. The iterative divide datapath consumes these results.

## Interface
- `WIDTH`, 64, operand width; power of two, 4..64 only.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset, synchronous and active-low.
- `InValid`  in  1  operand pair valid.
- `InReady`  out  1  block can accept operands.
- `X`  in  WIDTH  dividend, unsigned.
- `D`  in  WIDTH  divisor, unsigned.
- `OutValid`  out  1  results valid.
- `OutReady`  in  1  consumer accepts results.
- `XNorm`  out  WIDTH  `X << XShift`.
- `DNorm`  out  WIDTH  `D << DShift`.
- `XShift`  out  $clog2(WIDTH)  leading zeros of `X`.
- `DShift`  out  $clog2(WIDTH)  leading zeros of `D`.
- `XZero`  out  1  `X == 0`.
- `DivZero`  out  1  `D == 0`.
- `Iter`  out  $clog2(WIDTH)+1  number of quotient bits to generate.

## Operation
- FSM states: IDLE, LZX, LZD, SHIFT, DONE.
  - IDLE: `InReady=1`. On `InValid`, latch `X` and `D` into XReg/DReg, then go to LZX.
  - LZX: the LZD input mux selects XReg. Register `XShift=ZP` and `XZero=~ZV`, then go to LZD.
  - LZD: the mux selects DReg. Register `DShift=ZP` and `DivZero=~ZV`, then go to SHIFT.
  - SHIFT: register `XNorm`, `DNorm` and `Iter`, then go to DONE.
  - DONE: `OutValid=1` and all result outputs are held stable. On `OutReady`, go to IDLE, or to LZX if new operands are accepted on the same edge.
- `InReady = (state==IDLE) | (state==DONE & OutReady)`. A handshake on the DONE edge retires the old result and latches the new operands on that same edge.
- LZD convention: for a nonzero input, ZP is the leading-zero count. For a zero input, ZP is all ones (WIDTH-1) and ZV=0.
- Zero operands:
  - If the operand is zero, its shift output is WIDTH-1 and its Norm output is 0.
  - The flag (`XZero` or `DivZero`) is the only indicator of a zero operand.
- `Iter` rules:
  - `Iter = 0` if `XZero | DivZero | (XShift > DShift)`.
  - Otherwise `Iter = DShift - XShift + 1`, computed zero-extended to $clog2(WIDTH)+1 bits. The maximum is WIDTH.
- Behaviour on `DivZero` is unchanged: the block still completes all four states. The divider applies the RISC-V divide-by-zero result itself.

## Timing
- Reset (resetn=0 at an edge): state goes to IDLE. All registered outputs clear to 0 (`OutValid`, `XNorm`, `DNorm`, `XShift`, `DShift`, `XZero`, `DivZero`, `Iter`). `InReady` is 1 in the cycle after reset.
- Reset mid-operation: the in-flight operation is dropped with no output pulse.
- Latency: call the accepting edge E0.
  - XShift is captured at E1.
  - DShift is captured at E2.
  - Results are captured and `OutValid` rises at E3, i.e. valid in the cycle following E3.
- Throughput:
  - One operation per 4 cycles with `OutReady` tied high and `InValid` held high.
  - With `OutReady=0`, DONE holds indefinitely with outputs stable and `InReady=0`.
- `InValid` is ignored in LZX, LZD and SHIFT. Upstream holds its operands until the handshake.

## Structure
- Package `intdiv_pkg`: `typedef enum logic [2:0] {IDLE, LZX, LZD, SHIFT, DONE} prenorm_state_t`. `Iter` width is expressed via `$clog2(WIDTH)+1`.
- One sub-module instance: the existing `lzd_hier #(WIDTH)`, shared by both operands through a 2:1 mux selected by state.
- Shifters are plain `<<` operators registered in SHIFT. There is no separate shifter module.

## Test plan
- WIDTH=8, X=0x30, D=0x05, OutReady=1 → after E3: XShift=2, DShift=5, XNorm=0xC0, DNorm=0xA0, Iter=4, flags 0.
- WIDTH=8, X=0x03, D=0x40 → Iter=0 (XShift=6 > DShift=1), XNorm=0xC0, DNorm=0x80.
- WIDTH=8, D=0x00, X=0x11 → DivZero=1, DShift=7, DNorm=0x00, Iter=0. X=0, D=0x01 → XZero=1, Iter=0.
- WIDTH=64, X=0xFFFF_FFFF_FFFF_FFFF, D=1 → XShift=0, DShift=63, Iter=64 (MSB of 7-bit Iter set).
- Back-pressure: OutReady=0 for 10 cycles → outputs stable, InReady=0. Then OutReady=1 with InValid=1 → new operands accepted on the same edge, next OutValid 4 cycles later.
- Reset: resetn=0 during LZD → next cycle state IDLE, OutValid=0, all outputs 0, InReady=1. No spurious OutValid afterwards.
